// File: rtl/text_console_writer.sv
// Byte-stream console front end for the 80x30 text buffer: cursor tracking, control codes, screen/line clears.
// Optional CLEAR_LINE state is enabled by defining TEXT_CONSOLE_LINE_CLEAR_EN.
module text_console_writer #(
    parameter int           COLS       = 80,
    parameter int           ROWS       = 30,
    parameter int           ADDR_WIDTH = 12,
    parameter logic [7:0]   BLANK_CHAR = 8'h20
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [7:0]            din,
    output logic [6:0]            cursor_col,
    output logic [4:0]            cursor_row,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_CLEAR_ALL  = 2'd0,
        S_IDLE       = 2'd1
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
        , S_CLEAR_LINE = 2'd2
`endif
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(COLS*ROWS - 1);
    localparam logic [6:0]            LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]            LAST_ROW  = 5'(ROWS - 1);
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_LINE_CNT = ADDR_WIDTH'(COLS - 1);
`endif

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_nx;
    logic                    we_nx;
    logic [ADDR_WIDTH-1:0]   waddr_nx;
    logic [7:0]              din_nx;
    logic [6:0]              col_nx;
    logic [4:0]              row_nx;
    logic                    accept;
    logic                    printable;
    logic [4:0]              row_inc;
    logic [ADDR_WIDTH-1:0]   cur_addr;

    // row*80 built from shifts; the buffer is fixed at 80 columns
    function automatic logic [ADDR_WIDTH-1:0] row_base(input logic [4:0] r);
        logic [ADDR_WIDTH-1:0] rw;
        rw = ADDR_WIDTH'(r);
        return (rw << 6) + (rw << 4);
    endfunction

    assign accept    = in_valid && (state == S_IDLE);
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign row_inc   = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
    assign cur_addr  = row_base(cursor_row) + ADDR_WIDTH'(cursor_col);
    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
    logic row_adv;
    assign row_adv = accept && ((in_data == 8'h0A) || (printable && cursor_col == LAST_COL));
`endif

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR_ALL;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        case (state)
            S_CLEAR_ALL: begin
                clr_cnt_nx = clr_cnt + ADDR_WIDTH'(1);
                if (clr_cnt == LAST_CELL) begin
                    state_nx   = S_IDLE;
                    clr_cnt_nx = '0;
                end
            end
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
            S_CLEAR_LINE: begin
                clr_cnt_nx = clr_cnt + ADDR_WIDTH'(1);
                if (clr_cnt == LAST_LINE_CNT) begin
                    state_nx   = S_IDLE;
                    clr_cnt_nx = '0;
                end
            end
`endif
            S_IDLE: begin
                if (accept && in_data == 8'h0C) begin
                    state_nx   = S_CLEAR_ALL;
                    clr_cnt_nx = '0;
                end
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
                else if (row_adv) begin
                    state_nx   = S_CLEAR_LINE;
                    clr_cnt_nx = '0;
                end
`endif
            end
            default: begin
                state_nx   = S_CLEAR_ALL;
                clr_cnt_nx = '0;
            end
        endcase
    end

    always_comb begin
        we_nx    = 1'b0;
        waddr_nx = waddr;
        din_nx   = din;
        col_nx   = cursor_col;
        row_nx   = cursor_row;
        case (state)
            S_CLEAR_ALL: begin
                we_nx    = 1'b1;
                waddr_nx = clr_cnt;
                din_nx   = BLANK_CHAR;
                if (clr_cnt == LAST_CELL) begin
                    col_nx = '0;
                    row_nx = '0;
                end
            end
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
            S_CLEAR_LINE: begin
                we_nx    = 1'b1;
                waddr_nx = row_base(cursor_row) + clr_cnt;
                din_nx   = BLANK_CHAR;
            end
`endif
            S_IDLE: begin
                if (accept) begin
                    if (printable) begin
                        we_nx    = 1'b1;
                        waddr_nx = cur_addr;
                        din_nx   = in_data;
                        if (cursor_col == LAST_COL) begin
                            col_nx = '0;
                            row_nx = row_inc;
                        end else begin
                            col_nx = cursor_col + 7'd1;
                        end
                    end else if (in_data == 8'h0A) begin
                        col_nx = '0;
                        row_nx = row_inc;
                    end else if (in_data == 8'h0D) begin
                        col_nx = '0;
                    end else if (in_data == 8'h08 && cursor_col != 7'd0) begin
                        // Backspace never wraps to the previous row
                        col_nx   = cursor_col - 7'd1;
                        we_nx    = 1'b1;
                        waddr_nx = cur_addr - ADDR_WIDTH'(1);
                        din_nx   = BLANK_CHAR;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            write_en   <= 1'b0;
            waddr      <= '0;
            din        <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            write_en   <= we_nx;
            waddr      <= waddr_nx;
            din        <= din_nx;
            cursor_col <= col_nx;
            cursor_row <= row_nx;
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: clears, printables, control codes, row wrap, reset abort.
module tb_text_console_writer;

    logic        wclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        write_en;
    logic [11:0] waddr;
    logic [7:0]  din;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    text_console_writer dut (
        .wclk       (wclk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .write_en   (write_en),
        .waddr      (waddr),
        .din        (din),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 wclk = ~wclk;

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr(input logic we, input logic [11:0] a,
                                       input logic [7:0] d, input logic rdy);
        return {10'd0, we, a, d, rdy};
    endfunction

    function automatic logic [31:0] cur(input int c, input int r);
        return {20'd0, 7'(c), 5'(r)};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 5000) begin
            tick();
            n++;
        end
        check("ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready();
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_clear_all(input string tag);
        for (int i = 0; i < 2400; i++) begin
            tick();
            check(tag, wr(write_en, waddr, din, in_ready), wr(1'b1, 12'(i), 8'h20, i == 2399));
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_outputs", wr(write_en, waddr, din, in_ready), wr(1'b0, 12'd0, 8'h00, 1'b0));
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_cursor", cur(cursor_col, cursor_row), cur(0, 0));

        rst_n = 1'b1;
        check_clear_all("clear_all_reset");
        check("post_clear_cursor", cur(cursor_col, cursor_row), cur(0, 0));
        check("post_clear_busy", {31'd0, busy}, 32'd0);

        // "A","B" back-to-back
        in_valid = 1'b1; in_data = 8'h41; tick();
        check("wr_A", wr(write_en, waddr, din, in_ready), wr(1'b1, 12'd0, 8'h41, 1'b1));
        in_data = 8'h42; tick();
        check("wr_B", wr(write_en, waddr, din, in_ready), wr(1'b1, 12'd1, 8'h42, 1'b1));
        in_valid = 1'b0; tick();
        check("idle_no_write", {31'd0, write_en}, 32'd0);
        check("cursor_AB", cur(cursor_col, cursor_row), cur(2, 0));

        send(8'h0D);
        check("cr_no_write", {31'd0, write_en}, 32'd0);
        check("cursor_cr", cur(cursor_col, cursor_row), cur(0, 0));
        send(8'h08);
        check("bs_col0_no_write", {31'd0, write_en}, 32'd0);
        check("cursor_bs_col0", cur(cursor_col, cursor_row), cur(0, 0));
        send(8'h07);
        check("ignored_byte", {31'd0, write_en}, 32'd0);

        // Move to (3,2) and backspace
        send(8'h0A); send(8'h0A);
        send(8'h78); send(8'h79); send(8'h7A);
        check("cursor_3_2", cur(cursor_col, cursor_row), cur(3, 2));
        send(8'h08);
        check("bs_write", wr(write_en, waddr, din, 1'b0), wr(1'b1, 12'd162, 8'h20, 1'b0));
        check("cursor_bs", cur(cursor_col, cursor_row), cur(2, 2));

        // 80 printables on row 5
        send(8'h0D); send(8'h0A); send(8'h0A); send(8'h0A);
        wait_ready();
        check("cursor_row5", cur(cursor_col, cursor_row), cur(0, 5));
        in_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            in_data = 8'h41 + 8'(i % 26);
            tick();
            check("row5_char", wr(write_en, waddr, din, 1'b0),
                  wr(1'b1, 12'(400 + i), 8'h41 + 8'(i % 26), 1'b0));
        end
        in_valid = 1'b0;
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
        for (int j = 0; j < 80; j++) begin
            tick();
            check("row6_clear", wr(write_en, waddr, din, in_ready), wr(1'b1, 12'(480 + j), 8'h20, j == 79));
        end
`else
        tick();
        check("row6_no_clear", wr(write_en, 12'd0, 8'd0, in_ready), wr(1'b0, 12'd0, 8'd0, 1'b1));
`endif
        check("cursor_row6", cur(cursor_col, cursor_row), cur(0, 6));

        // Wrap from row 29
        for (int i = 0; i < 23; i++) send(8'h0A);
        wait_ready();
        check("cursor_row29", cur(cursor_col, cursor_row), cur(0, 29));
        in_valid = 1'b1; in_data = 8'h0A; tick(); in_valid = 1'b0;
        check("lf_no_char", {31'd0, write_en}, 32'd0);
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
        for (int j = 0; j < 80; j++) begin
            tick();
            check("row0_clear", wr(write_en, waddr, din, in_ready), wr(1'b1, 12'(j), 8'h20, j == 79));
        end
`endif
        check("cursor_wrap", cur(cursor_col, cursor_row), cur(0, 0));

        // Printable at col 79 of row 1, then next byte
        send(8'h0A);
        for (int i = 0; i < 79; i++) send(8'h61);
        wait_ready();
        check("cursor_79_1", cur(cursor_col, cursor_row), cur(79, 1));
        in_valid = 1'b1; in_data = 8'h5A; tick();
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
        check("wr_Z", wr(write_en, waddr, din, in_ready), wr(1'b1, 12'd159, 8'h5A, 1'b0));
        in_data = 8'h51;
        for (int j = 0; j < 80; j++) begin
            tick();
            check("row2_clear", wr(write_en, waddr, din, in_ready), wr(1'b1, 12'(160 + j), 8'h20, j == 79));
        end
`else
        check("wr_Z", wr(write_en, waddr, din, in_ready), wr(1'b1, 12'd159, 8'h5A, 1'b1));
        in_data = 8'h51;
`endif
        tick();
        check("wr_Q", wr(write_en, waddr, din, in_ready), wr(1'b1, 12'd160, 8'h51, 1'b1));
        in_valid = 1'b0;
        check("cursor_Q", cur(cursor_col, cursor_row), cur(1, 2));

        // Form feed with a byte held by the source during the clear
        send(8'h0C);
        check("ff_ready_drop", wr(write_en, 12'd0, 8'd0, in_ready), wr(1'b0, 12'd0, 8'd0, 1'b0));
        in_valid = 1'b1; in_data = 8'h4B;
        check_clear_all("clear_all_ff");
        tick();
        check("held_byte", wr(write_en, waddr, din, in_ready), wr(1'b1, 12'd0, 8'h4B, 1'b1));
        in_valid = 1'b0;
        check("cursor_after_held", cur(cursor_col, cursor_row), cur(1, 0));

        // Reset during a clear aborts and restarts from address 0
        send(8'h0C);
        for (int i = 0; i < 5; i++) tick();
        check("ff_progress", wr(write_en, waddr, din, in_ready), wr(1'b1, 12'd4, 8'h20, 1'b0));
        rst_n = 1'b0;
        #1;
        check("abort_outputs", wr(write_en, waddr, din, in_ready), wr(1'b0, 12'd0, 8'h00, 1'b0));
        check("abort_cursor", cur(cursor_col, cursor_row), cur(0, 0));
        tick();
        rst_n = 1'b1;
        tick();
        check("restart_addr0", wr(write_en, waddr, din, in_ready), wr(1'b1, 12'd0, 8'h20, 1'b0));
        tick();
        check("restart_addr1", wr(write_en, waddr, din, in_ready), wr(1'b1, 12'd1, 8'h20, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
